// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: FSM state encoding, line levels and helpers for uart_tx (ST_PARITY exists only with `UART_TX_PARITY_EN)
package uart_tx_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic LINE_START = 1'b0;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/uart_tx_bit_timer.sv
// uart_tx_bit_timer: counts 2*p_BITSLOT_HALF_PERIOD clocks per slot and pulses o_slot_end on the last clock
module uart_tx_bit_timer #(
  parameter int p_BITSLOT_HALF_PERIOD = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_restart,
  input  logic i_en,
  output logic o_slot_end
);
  localparam int T = 2 * p_BITSLOT_HALF_PERIOD;
  localparam int TW = $clog2(T);
  logic [TW-1:0] cnt;
  assign o_slot_end = i_en && cnt == TW'(T - 1);
  always_ff @(posedge i_clk)
    if (i_rst || i_restart) cnt <= '0;
    else if (i_en) cnt <= o_slot_end ? '0 : cnt + TW'(1);
endmodule

// File: rtl/uart_tx.sv
// uart_tx: valid/ready UART serialiser: start bit, LSB-first data, even parity when `UART_TX_PARITY_EN is defined, stop bits.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int p_BITSLOT_HALF_PERIOD = 1,
  parameter int p_DATA_BITS = 8,
  parameter int p_STOP_BITS = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [p_DATA_BITS-1:0] i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic                   o_tx,
  output logic                   o_done
);
  localparam int CW = $clog2(max2(p_DATA_BITS, p_STOP_BITS) + 1);
  localparam logic [CW-1:0] LAST_D = CW'(p_DATA_BITS - 1);
  localparam logic [CW-1:0] LAST_S = CW'(p_STOP_BITS - 1);
  if (p_BITSLOT_HALF_PERIOD < 1 || p_DATA_BITS < 1 || p_DATA_BITS > 16 || p_STOP_BITS < 1 || p_STOP_BITS > 4) begin : g_bad_params
    $error("uart_tx: illegal parameters");
  end
  state_t st, st_n;
  logic [p_DATA_BITS-1:0] sh, sh_n;
  logic [CW-1:0] cnt, cnt_n;
  logic tx_n, done_n, slot_end, accept, last_stop;
`ifdef UART_TX_PARITY_EN
  logic par, par_n;
`endif
  // Ready during the final stop clock so a held i_valid starts the next frame with no idle gap
  assign last_stop = st == ST_STOP && slot_end && cnt == LAST_S;
  assign o_ready = st == ST_IDLE || last_stop;
  assign accept = i_valid && o_ready;
  uart_tx_bit_timer #(.p_BITSLOT_HALF_PERIOD(p_BITSLOT_HALF_PERIOD)) u_timer (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_restart(accept),
    .i_en(st != ST_IDLE),
    .o_slot_end(slot_end)
  );
  always_comb begin
    st_n = st;
    sh_n = sh;
    cnt_n = cnt;
    tx_n = o_tx;
    done_n = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n = par;
`endif
    case (st)
      ST_IDLE: tx_n = LINE_IDLE;
      ST_START: if (slot_end) begin
        st_n = ST_DATA;
        tx_n = sh[0];
        cnt_n = '0;
      end
      ST_DATA: if (slot_end) begin
        if (cnt == LAST_D) begin
          cnt_n = '0;
`ifdef UART_TX_PARITY_EN
          st_n = ST_PARITY;
          tx_n = par;
`else
          st_n = ST_STOP;
          tx_n = LINE_IDLE;
`endif
        end else begin
          sh_n = sh >> 1;
          tx_n = sh_n[0];
          cnt_n = cnt + CW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: if (slot_end) begin
        st_n = ST_STOP;
        tx_n = LINE_IDLE;
      end
`endif
      ST_STOP: if (slot_end) begin
        st_n = last_stop ? ST_IDLE : ST_STOP;
        cnt_n = last_stop ? '0 : cnt + CW'(1);
        done_n = last_stop;
        tx_n = LINE_IDLE;
      end
      default: st_n = ST_IDLE;
    endcase
    if (accept) begin
      st_n = ST_START;
      sh_n = i_data;
      cnt_n = '0;
      tx_n = LINE_START;
`ifdef UART_TX_PARITY_EN
      par_n = ^i_data;
`endif
    end
  end
  always_ff @(posedge i_clk)
    if (i_rst) begin
      st <= ST_IDLE;
      sh <= '0;
      cnt <= '0;
      o_tx <= LINE_IDLE;
      o_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      st <= st_n;
      sh <= sh_n;
      cnt <= cnt_n;
      o_tx <= tx_n;
      o_done <= done_n;
`ifdef UART_TX_PARITY_EN
      par <= par_n;
`endif
    end
endmodule
